// File: rtl/i2c_target_regs.sv
// i2c_target_regs: 7-bit-address I2C target with an NBYTES x 8-bit byte buffer.
// Bus writes land in the buffer at an auto-incrementing pointer and bus reads
// return buffer bytes from the same pointer. The pointer restarts at 0 on every
// START. A host-side port preloads the buffer and reads it back. SCL is only
// sampled and is never stretched.
//
// Ports
//   clk, rst              sample clock (>= 8x SCL), synchronous active-low reset
//   i2c_scl               bus clock input
//   i2c_sda               open-drain data: driven 0 or released (z)
//   mem_we/waddr/wdata    host write into the buffer
//   mem_raddr/mem_rdata   host read-back, combinational
//   rx_valid/data/index   1-cycle pulse per committed bus-write byte
//   busy                  address matched, transfer in progress
//   xfer_done             1-cycle pulse on the STOP that ends an addressed transfer
module i2c_target_regs #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned NBYTES      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned PW         = $clog2(NBYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i2c_scl,
  inout  wire           i2c_sda,
  input  logic          mem_we,
  input  logic [PW-1:0] mem_waddr,
  input  logic [7:0]    mem_wdata,
  input  logic [PW-1:0] mem_raddr,
  output logic [7:0]    mem_rdata,
  output logic          rx_valid,
  output logic [7:0]    rx_data,
  output logic [PW-1:0] rx_index,
  output logic          busy,
  output logic          xfer_done
);

  localparam int unsigned BCW = 3;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_MACK, WAIT_STOP
  } state_t;

  // Input synchronizers and one-cycle-delayed copies for edge detection.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_d1_q, sda_d1_q;
  logic                   scl_s, sda_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_d1_q   <= 1'b1;
      sda_d1_q   <= 1'b1;
    end else begin
      scl_sync_q <= SYNC_STAGES'({scl_sync_q, i2c_scl});
      sda_sync_q <= SYNC_STAGES'({sda_sync_q, i2c_sda});
      scl_d1_q   <= scl_s;
      sda_d1_q   <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_s & ~scl_d1_q;
  assign scl_fall  = ~scl_s &  scl_d1_q;
  assign start_det =  scl_s &  sda_d1_q & ~sda_s;
  assign stop_det  =  scl_s & ~sda_d1_q &  sda_s;

  // Protocol state.
  state_t           state_q, state_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             sda_pull_q, sda_pull_d;
  logic             busy_q, busy_d;
  logic             rw_q, rw_d;
  logic             first_q, first_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [PW-1:0]    rx_index_q, rx_index_d;
  logic             xfer_done_q, xfer_done_d;

  logic [7:0]       mem_q [NBYTES];
  logic             bus_we_c;
  logic [7:0]       bus_wdata_c;
  logic [PW-1:0]    ptr_inc_c;
  logic [7:0]       in_byte_c;

  assign ptr_inc_c = ptr_q + PW'(1);
  assign in_byte_c = {shift_q[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      sda_pull_q  <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      first_q     <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_index_q  <= '0;
      xfer_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_pull_q  <= sda_pull_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      rx_index_q  <= rx_index_d;
      xfer_done_q <= xfer_done_d;
    end
  end

  // Next-state logic. STOP and START override any state, even mid-byte.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_pull_d  = sda_pull_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    first_d     = first_q;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    rx_index_d  = rx_index_q;
    xfer_done_d = 1'b0;
    bus_we_c    = 1'b0;
    bus_wdata_c = in_byte_c;

    if (stop_det) begin
      state_d     = IDLE;
      sda_pull_d  = 1'b0;
      xfer_done_d = busy_q;
      busy_d      = 1'b0;
    end else if (start_det) begin
      state_d    = ADDR;
      bitcnt_d   = '0;
      ptr_d      = '0;
      sda_pull_d = 1'b0;
      busy_d     = 1'b0;
      first_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end

        ADDR: begin
          if (scl_rise) begin
            shift_d  = in_byte_c;
            bitcnt_d = bitcnt_q + BCW'(1);
            if (bitcnt_q == BCW'(7)) begin
              bitcnt_d = '0;
              if (shift_q[6:0] == TARGET_ADDR) begin
                busy_d  = 1'b1;
                rw_d    = sda_s;
                state_d = ADDR_ACK;
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end

        // First fall pulls SDA for the ACK slot, second fall releases it.
        ADDR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!sda_pull_q) begin
              sda_pull_d = 1'b1;
            end else begin
              sda_pull_d = 1'b0;
              bitcnt_d   = '0;
              if (state_q == ADDR_ACK && rw_q) begin
                // Bit 7 goes out on this same fall.
                state_d    = RD_BYTE;
                shift_d    = mem_q[ptr_q];
                sda_pull_d = ~mem_q[ptr_q][7];
                first_d    = 1'b0;
              end else begin
                state_d = WR_BYTE;
              end
            end
          end
        end

        WR_BYTE: begin
          if (scl_rise) begin
            shift_d  = in_byte_c;
            bitcnt_d = bitcnt_q + BCW'(1);
            if (bitcnt_q == BCW'(7)) begin
              bitcnt_d   = '0;
              bus_we_c   = 1'b1;
              rx_valid_d = 1'b1;
              rx_data_d  = in_byte_c;
              rx_index_d = ptr_q;
              ptr_d      = ptr_inc_c;
              state_d    = WR_ACK;
            end
          end
        end

        // first_q: byte loaded after a master ACK, bit 7 not yet presented.
        RD_BYTE: begin
          if (scl_fall) begin
            if (first_q) begin
              sda_pull_d = ~shift_q[7];
              first_d    = 1'b0;
            end else if (bitcnt_q == BCW'(7)) begin
              sda_pull_d = 1'b0;
              bitcnt_d   = '0;
              state_d    = RD_MACK;
            end else begin
              shift_d    = {shift_q[6:0], 1'b0};
              sda_pull_d = ~shift_q[6];
              bitcnt_d   = bitcnt_q + BCW'(1);
            end
          end
        end

        RD_MACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_d    = ptr_inc_c;
              shift_d  = mem_q[ptr_inc_c];
              first_d  = 1'b1;
              bitcnt_d = '0;
              state_d  = RD_BYTE;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end

        WAIT_STOP: begin
          sda_pull_d = 1'b0;
        end

        default: begin
          state_d    = IDLE;
          sda_pull_d = 1'b0;
        end
      endcase
    end
  end

  // Buffer: a bus commit is applied after the host write so it wins on a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NBYTES); i++) mem_q[i] <= '0;
    end else begin
      if (mem_we)   mem_q[mem_waddr] <= mem_wdata;
      if (bus_we_c) mem_q[ptr_q]     <= bus_wdata_c;
    end
  end

  assign mem_rdata = mem_q[mem_raddr];
  assign i2c_sda   = sda_pull_q ? 1'b0 : 1'bz;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign rx_index  = rx_index_q;
  assign busy      = busy_q;
  assign xfer_done = xfer_done_q;

endmodule
